// File: rtl/rf_pkg.sv
// Shared constants and reset-image helper for the parametrised register file.
package rf_pkg;

    localparam logic [31:0] RF_PROT_DEFAULT      = 32'h0C00_0001;
    localparam logic [31:0] RF_ZERO_DEFAULT      = 32'hD000_0000;
    localparam int unsigned RF_SP_IDX_DEFAULT    = 29;
    localparam int unsigned RF_SP_INIT_DEFAULT   = 1020;
    localparam int unsigned RF_INIT_BASE_DEFAULT = 100;

    // Reset value of register idx; callers truncate to their data width.
    function automatic logic [63:0] rf_reset_value(
        input int unsigned idx,
        input logic        prot,
        input logic        zero,
        input int unsigned init_base,
        input int unsigned sp_idx,
        input logic [63:0] sp_init
    );
        if (prot || zero) begin
            return 64'd0;
        end else if (idx == sp_idx) begin
            return sp_init;
        end else begin
            return 64'(idx) + 64'(init_base);
        end
    endfunction

endpackage

// File: rtl/param_register_file_if.sv
// Decode/writeback bus of the register file: two read ports, one write port, reservation and error.
interface param_register_file_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) ();

    logic [ADDR_W-1:0] RdAddr1;
    logic [ADDR_W-1:0] RdAddr2;
    logic [DATA_W-1:0] RdData1;
    logic [DATA_W-1:0] RdData2;
    logic              Busy1;
    logic              Busy2;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [DATA_W-1:0] WrData;
    logic              ResvEn;
    logic [ADDR_W-1:0] ResvAddr;
    logic              ErrClr;
    logic              WrErr;
    logic [DATA_W-1:0] v0;
    logic [DATA_W-1:0] v1;

    modport master (
        output RdAddr1, RdAddr2, WrEn, WrAddr, WrData, ResvEn, ResvAddr, ErrClr,
        input  RdData1, RdData2, Busy1, Busy2, WrErr, v0, v1
    );

    modport slave (
        input  RdAddr1, RdAddr2, WrEn, WrAddr, WrData, ResvEn, ResvAddr, ErrClr,
        output RdData1, RdData2, Busy1, Busy2, WrErr, v0, v1
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, reservation wins over a same-edge retire.
module rf_scoreboard #(
    parameter int unsigned             ADDR_W    = 5,
    parameter logic [2**ADDR_W-1:0]    PROT_MASK = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] look_addr1,
    input  logic [ADDR_W-1:0] look_addr2,
    output logic              busy1_c,
    output logic              busy2_c
);

    localparam int unsigned NREGS = 2**ADDR_W;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clear first so a coincident reservation overrides it; protected bits never set.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en && !PROT_MASK[set_addr]) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1_c = busy_q[look_addr1];
    assign busy2_c = busy_q[look_addr2];

endmodule

// File: rtl/param_register_file.sv
// Parametrised two-read/one-write register file with reset images, protection, bypass and hazard scoreboard.
module param_register_file
    import rf_pkg::*;
#(
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          ADDR_W    = 5,
    parameter int unsigned          INIT_BASE = RF_INIT_BASE_DEFAULT,
    parameter int unsigned          SP_IDX    = RF_SP_IDX_DEFAULT,
    parameter int unsigned          SP_INIT   = RF_SP_INIT_DEFAULT,
    parameter logic [2**ADDR_W-1:0] PROT_MASK = (2**ADDR_W)'(RF_PROT_DEFAULT),
    parameter logic [2**ADDR_W-1:0] ZERO_MASK = (2**ADDR_W)'(RF_ZERO_DEFAULT),
    parameter bit                   BYPASS    = 1'b1
) (
    input  logic                Clk,
    input  logic                Rst_n,
    param_register_file_if.slave bus
);

    localparam int unsigned NREGS = 2**ADDR_W;

    function automatic logic [NREGS-1:0][DATA_W-1:0] build_image();
        logic [NREGS-1:0][DATA_W-1:0] img;
        for (int unsigned i = 0; i < NREGS; i++) begin
            img[i] = DATA_W'(rf_reset_value(i, PROT_MASK[i], ZERO_MASK[i],
                                            INIT_BASE, SP_IDX, 64'(SP_INIT)));
        end
        return img;
    endfunction

    localparam logic [NREGS-1:0][DATA_W-1:0] RST_IMG = build_image();

    logic [NREGS-1:0][DATA_W-1:0] regs_q;
    logic [NREGS-1:0][DATA_W-1:0] regs_d;
    logic                         wr_err_q;
    logic                         wr_err_d;
    logic                         wr_commit_c;
    logic                         wr_prot_c;
    logic                         fwd1_c;
    logic                         fwd2_c;
    logic                         sb_busy1_c;
    logic                         sb_busy2_c;

    assign wr_commit_c = bus.WrEn & ~PROT_MASK[bus.WrAddr];
    assign wr_prot_c   = bus.WrEn &  PROT_MASK[bus.WrAddr];

    // Protected registers are never written, so they keep their reset image.
    always_comb begin
        regs_d = regs_q;
        if (wr_commit_c) begin
            regs_d[bus.WrAddr] = bus.WrData;
        end
    end

    // A protected-write attempt outranks a clear on the same edge.
    always_comb begin
        wr_err_d = wr_err_q;
        if (bus.ErrClr) begin
            wr_err_d = 1'b0;
        end
        if (wr_prot_c) begin
            wr_err_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            regs_q   <= RST_IMG;
            wr_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign fwd1_c = BYPASS && wr_commit_c && (bus.WrAddr == bus.RdAddr1);
    assign fwd2_c = BYPASS && wr_commit_c && (bus.WrAddr == bus.RdAddr2);

    rf_scoreboard #(
        .ADDR_W    (ADDR_W),
        .PROT_MASK (PROT_MASK)
    ) u_scoreboard (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .set_en     (bus.ResvEn),
        .set_addr   (bus.ResvAddr),
        .clr_en     (wr_commit_c),
        .clr_addr   (bus.WrAddr),
        .look_addr1 (bus.RdAddr1),
        .look_addr2 (bus.RdAddr2),
        .busy1_c    (sb_busy1_c),
        .busy2_c    (sb_busy2_c)
    );

    assign bus.RdData1 = fwd1_c ? bus.WrData : regs_q[bus.RdAddr1];
    assign bus.RdData2 = fwd2_c ? bus.WrData : regs_q[bus.RdAddr2];
    assign bus.Busy1   = sb_busy1_c & ~fwd1_c;
    assign bus.Busy2   = sb_busy2_c & ~fwd2_c;
    assign bus.WrErr   = wr_err_q;
    assign bus.v0      = regs_q[2];
    assign bus.v1      = regs_q[3];

endmodule
